eth_frame_tx: RTL and testbench

ETH_FRAME_TX -- requirements
Module: eth_frame_tx

---
 rtl/eth_frame_tx.sv | 199 +++++++++++++++++++
 tb/tb_eth_frame_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx.sv
// rtl/eth_frame_tx.sv - ARP / UDP-over-IPv4 Ethernet frame serializer, 32-bit words
// Define ETH_TX_PAD_EN to zero-pad every frame to at least 16 words.
module eth_frame_tx #(
  parameter int          LEN_W      = 9,
  parameter int          IFG_CYCLES = 12,
  parameter logic [15:0] SRC_PORT   = 16'd2179,
  parameter logic [15:0] DST_PORT   = 16'd5152,
  parameter logic [7:0]  TTL        = 8'hC8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [3:0]       i_pkt_type,
  input  logic [LEN_W-1:0] i_len_words,
  input  logic [47:0]      i_self_mac,
  input  logic [31:0]      i_self_ip,
  input  logic [47:0]      i_target_mac,
  input  logic [31:0]      i_target_ip,
  input  logic [31:0]      i_pl_data,
  input  logic             i_pl_vld,
  output logic             o_pl_rdy,
  output logic [31:0]      o_data,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_busy,
  output logic             o_err
);
  localparam int CW = LEN_W + 5;
  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam logic [3:0] T_ARP_REQ = 4'd1;
  localparam logic [3:0] T_ARP_RSP = 4'd2;
  localparam logic [3:0] T_UDP     = 4'd3;

`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, PAD, IFG} state_t;
`else
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, IFG} state_t;
`endif

  state_t            state_q, state_d;
  logic [3:0]        type_q;
  logic [LEN_W-1:0]  len_q;
  logic [47:0]       smac_q, tmac_q;
  logic [31:0]       sip_q, tip_q;
  logic [15:0]       csum_q, csum_d;
  logic [15:0]       ip_id_q;
  logic [CW-1:0]     wcnt_q;
  logic [LEN_W-1:0]  pcnt_q;
  logic [IW-1:0]     ifg_q;
  logic              err_q;

  logic        type_ok, start_ok, start_bad, is_udp, pl_last, hdr_last, ifg_last, xfer;
  logic [15:0] iplen, udplen, oper;
  logic [19:0] csum_sum;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;
  logic [31:0] hdr_word, data_c;
  logic        vld_c, sop_c, eop_c, pl_rdy_c;

  assign type_ok   = (i_pkt_type == T_ARP_REQ) || (i_pkt_type == T_ARP_RSP) ||
                     ((i_pkt_type == T_UDP) && (i_len_words != '0));
  assign start_ok  = (state_q == IDLE) && i_start && type_ok;
  assign start_bad = (state_q == IDLE) && i_start && !type_ok;
  assign is_udp    = (type_q == T_UDP);
  assign pl_last   = (pcnt_q == len_q - LEN_W'(1));
  assign hdr_last  = (wcnt_q == CW'(10));
  assign ifg_last  = (ifg_q == IW'(IFG_CYCLES - 1));
  assign xfer      = vld_c && i_rdy;

  assign iplen  = (16'(len_q) << 2) + 16'd28;
  assign udplen = (16'(len_q) << 2) + 16'd8;
  assign oper   = (type_q == T_ARP_RSP) ? 16'd2 : 16'd1;

  // Header checksum over the ten halfwords; flags/fragment and checksum field are zero.
  assign csum_sum = 20'h04500 + 20'(iplen) + 20'(ip_id_q) + 20'({TTL, 8'd17}) +
                    20'(sip_q[31:16]) + 20'(sip_q[15:0]) + 20'(tip_q[31:16]) + 20'(tip_q[15:0]);
  assign csum_f1  = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign csum_f2  = csum_f1[15:0] + 16'(csum_f1[16]);
  assign csum_d   = ~csum_f2;

  always_comb begin
    hdr_word = 32'h0;
    case (wcnt_q[3:0])
      4'd0:    hdr_word = {16'h0, tmac_q[47:32]};
      4'd1:    hdr_word = tmac_q[31:0];
      4'd2:    hdr_word = smac_q[47:16];
      4'd3:    hdr_word = {smac_q[15:0], is_udp ? 16'h0800 : 16'h0806};
      4'd4:    hdr_word = is_udp ? {8'h45, 8'h00, iplen} : {16'h0001, 16'h0800};
      4'd5:    hdr_word = is_udp ? {ip_id_q, 16'h0} : {8'h06, 8'h04, oper};
      4'd6:    hdr_word = is_udp ? {TTL, 8'd17, csum_q} : smac_q[47:16];
      4'd7:    hdr_word = is_udp ? sip_q : {smac_q[15:0], sip_q[31:16]};
      4'd8:    hdr_word = is_udp ? tip_q : {sip_q[15:0], tmac_q[47:32]};
      4'd9:    hdr_word = is_udp ? {SRC_PORT, DST_PORT} : tmac_q[31:0];
      4'd10:   hdr_word = is_udp ? {udplen, 16'h0} : tip_q;
      default: hdr_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      len_q   <= '0;
      smac_q  <= '0;
      tmac_q  <= '0;
      sip_q   <= '0;
      tip_q   <= '0;
      csum_q  <= '0;
      ip_id_q <= '0;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      ifg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      ifg_q   <= (state_q == IFG) ? ifg_q + IW'(1) : '0;
      if (start_ok) begin
        type_q <= i_pkt_type;
        len_q  <= i_len_words;
        smac_q <= i_self_mac;
        tmac_q <= i_target_mac;
        sip_q  <= i_self_ip;
        tip_q  <= i_target_ip;
        wcnt_q <= '0;
        pcnt_q <= '0;
      end else begin
        if (xfer) wcnt_q <= wcnt_q + CW'(1);
        if (xfer && state_q == PAYLOAD) pcnt_q <= pcnt_q + LEN_W'(1);
      end
      if (state_q == CSUM) csum_q <= csum_d;
      if (xfer && eop_c && is_udp) ip_id_q <= ip_id_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = CSUM;
      CSUM:    state_d = HDR;
`ifdef ETH_TX_PAD_EN
      HDR:     if (xfer && hdr_last) state_d = is_udp ? PAYLOAD : PAD;
      PAYLOAD: if (xfer && pl_last) state_d = (wcnt_q >= CW'(15)) ? IFG : PAD;
      PAD:     if (xfer && wcnt_q == CW'(15)) state_d = IFG;
`else
      HDR:     if (xfer && hdr_last) state_d = is_udp ? PAYLOAD : IFG;
      PAYLOAD: if (xfer && pl_last) state_d = IFG;
`endif
      IFG:     if (ifg_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_c   = 32'h0;
    vld_c    = 1'b0;
    sop_c    = 1'b0;
    eop_c    = 1'b0;
    pl_rdy_c = 1'b0;
    case (state_q)
      HDR: begin
        data_c = hdr_word;
        vld_c  = 1'b1;
        sop_c  = (wcnt_q == '0);
`ifndef ETH_TX_PAD_EN
        eop_c  = hdr_last && !is_udp;
`endif
      end
      PAYLOAD: begin
        data_c   = i_pl_data;
        vld_c    = i_pl_vld;
        pl_rdy_c = i_rdy;
`ifdef ETH_TX_PAD_EN
        eop_c    = pl_last && (wcnt_q >= CW'(15));
`else
        eop_c    = pl_last;
`endif
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        vld_c = 1'b1;
        eop_c = (wcnt_q == CW'(15));
      end
`endif
      default: ;
    endcase
  end

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign o_data   = rst ? 32'h0 : data_c;
  assign o_vld    = !rst && vld_c;
  assign o_sop    = !rst && sop_c;
  assign o_eop    = !rst && eop_c;
  assign o_pl_rdy = !rst && pl_rdy_c;
  assign o_busy   = !rst && ((state_q != IDLE) || start_ok);
  assign o_err    = !rst && err_q;
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb/tb_eth_frame_tx.sv - directed vector bench for eth_frame_tx
module tb_eth_frame_tx;
  localparam int LEN_W = 9;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam logic [47:0] SELF_MAC = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] TGT_MAC  = 48'h112233445566;
  localparam logic [31:0] SELF_IP  = 32'hC0A8010A;
  localparam logic [31:0] TGT_IP   = 32'hC0A80101;
  localparam logic [31:0] PL_BASE  = 32'hA5000000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic [3:0]       i_pkt_type = 4'd0;
  logic [LEN_W-1:0] i_len_words = '0;
  logic [31:0]      i_pl_data = 32'h0;
  logic             i_pl_vld = 1'b0;
  logic             i_rdy = 1'b1;
  logic             o_pl_rdy, o_vld, o_sop, o_eop, o_busy, o_err;
  logic [31:0]      o_data;

  always #5 clk = ~clk;

  eth_frame_tx dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pkt_type(i_pkt_type), .i_len_words(i_len_words),
    .i_self_mac(SELF_MAC), .i_self_ip(SELF_IP), .i_target_mac(TGT_MAC), .i_target_ip(TGT_IP),
    .i_pl_data(i_pl_data), .i_pl_vld(i_pl_vld), .o_pl_rdy(o_pl_rdy), .o_data(o_data), .o_vld(o_vld),
    .i_rdy(i_rdy), .o_sop(o_sop), .o_eop(o_eop), .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    logic [3:0]  ptype;
    int          len;
    int          mode;
    logic [31:0] w1, w4, w5, w6, w7, w11;
  } vec_t;

  vec_t        vecs[5];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] words[$];
  int          nsop, sop_pos, eop_pos, stall_bad, pl_bad, pl_idx, busy_cnt, ifg_vld;
  bit          done, busy_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_words(input logic [3:0] t, input int len);
    int n;
    n = (t == 4'd3) ? 11 + len : 11;
    if (PAD && n < 16) n = 16;
    return n;
  endfunction

  // mode 0: always ready; mode 1: i_rdy toggles, payload valid has gaps
  task automatic send_frame(input logic [3:0] t, input int len, input int mode, input int extra_start_at);
    bit          prev_stall;
    logic [31:0] pd;
    logic        ps, pe;
    words.delete();
    nsop = 0; sop_pos = 0; eop_pos = 0; stall_bad = 0; pl_bad = 0; pl_idx = 0;
    busy_cnt = 0; ifg_vld = 0; done = 0; prev_stall = 0; pd = '0; ps = 0; pe = 0;
    tick();
    i_start = 1'b1; i_pkt_type = t; i_len_words = len[LEN_W-1:0];
    #3 busy_acc = o_busy;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      i_rdy     = (mode == 1) ? c[0] : 1'b1;
      i_pl_vld  = (mode == 1) ? (c % 3 != 2) : 1'b1;
      i_pl_data = PL_BASE + pl_idx;
      i_start   = (c == extra_start_at);
      #3;
      if (prev_stall && o_vld && (o_data !== pd || o_sop !== ps || o_eop !== pe)) stall_bad++;
      prev_stall = o_vld && !i_rdy;
      pd = o_data; ps = o_sop; pe = o_eop;
      if (o_vld && i_rdy) begin
        words.push_back(o_data);
        if (o_sop) begin nsop++; sop_pos = words.size(); end
        if (o_pl_rdy) begin
          if (o_data !== PL_BASE + pl_idx) pl_bad++;
          pl_idx++;
        end
        if (o_eop) begin eop_pos = words.size(); done = 1; end
      end
      tick();
    end
    i_start = 1'b0; i_rdy = 1'b1; i_pl_vld = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (!o_busy) break;
      busy_cnt++;
      if (o_vld) ifg_vld++;
      tick();
    end
  endtask

  task automatic check_common(input string tag, input int exp_n, input int len, input bit udp);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_nwords"}, words.size(), exp_n);
    check({tag, "_nsop"}, nsop, 1);
    check({tag, "_sop_pos"}, sop_pos, 1);
    check({tag, "_eop_pos"}, eop_pos, exp_n);
    check({tag, "_stall_stable"}, stall_bad, 0);
    check({tag, "_busy_accept"}, 32'(busy_acc), 32'd1);
    check({tag, "_busy_ifg"}, busy_cnt, 12);
    check({tag, "_ifg_vld"}, ifg_vld, 0);
    if (udp) begin
      check({tag, "_pl_count"}, pl_idx, len);
      check({tag, "_pl_order"}, pl_bad, 0);
    end
  endtask

  initial begin
    int errc, vldc, busyc, n;
    bit eop_seen;
    //               type  len mode  w1            w4            w5            w6            w7            w11
    vecs[0] = '{4'd1, 0,  0, 32'h00001122, 32'h4E5F0806, 32'h00010800, 32'h06040001, 32'h0A1B2C3D, 32'hC0A80101};
    vecs[1] = '{4'd2, 0,  0, 32'h00001122, 32'h4E5F0806, 32'h00010800, 32'h06040002, 32'h0A1B2C3D, 32'hC0A80101};
    vecs[2] = '{4'd3, 32, 0, 32'h00001122, 32'h4E5F0800, 32'h4500009C, 32'h00000000, 32'hC8116EF5, 32'h00880000};
    vecs[3] = '{4'd3, 1,  0, 32'h00001122, 32'h4E5F0800, 32'h45000020, 32'h00010000, 32'hC8116F70, 32'h000C0000};
    vecs[4] = '{4'd3, 4,  1, 32'h00001122, 32'h4E5F0800, 32'h4500002C, 32'h00020000, 32'hC8116F63, 32'h00180000};

    tick(); tick();
    #3;
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_data", o_data, 32'h0);
    check("rst_flags", {28'h0, o_sop, o_eop, o_err, o_pl_rdy}, 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      send_frame(vecs[i].ptype, vecs[i].len, vecs[i].mode, -1);
      check_common(tag, frame_words(vecs[i].ptype, vecs[i].len), vecs[i].len, vecs[i].ptype == 4'd3);
      check({tag, "_w1"}, words[0], vecs[i].w1);
      check({tag, "_w4"}, words[3], vecs[i].w4);
      check({tag, "_w5"}, words[4], vecs[i].w5);
      check({tag, "_w6"}, words[5], vecs[i].w6);
      check({tag, "_w7"}, words[6], vecs[i].w7);
      check({tag, "_w11"}, words[10], vecs[i].w11);
    end

    // Unsupported type, then UDP with zero length: error pulse only
    for (int k = 0; k < 2; k++) begin
      tick();
      i_start = 1'b1; i_pkt_type = (k == 0) ? 4'd7 : 4'd3; i_len_words = '0;
      tick();
      i_start = 1'b0;
      errc = 0; vldc = 0; busyc = 0;
      for (int c = 0; c < 6; c++) begin
        #3;
        if (o_err) errc++;
        if (o_vld) vldc++;
        if (o_busy) busyc++;
        tick();
      end
      check($sformatf("rej%0d_err_pulse", k), errc, 1);
      check($sformatf("rej%0d_no_vld", k), vldc, 0);
      check($sformatf("rej%0d_no_busy", k), busyc, 0);
    end

    // Reset clears ip_id; two back-to-back UDP frames with stray starts while busy
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    send_frame(4'd3, 2, 0, 3);
    check_common("b2b_a", frame_words(4'd3, 2), 2, 1'b1);
    check("b2b_a_w6", words[5], 32'h00000000);
    send_frame(4'd3, 2, 0, 4);
    check_common("b2b_b", frame_words(4'd3, 2), 2, 1'b1);
    check("b2b_b_w6", words[5], 32'h00010000);
    vldc = 0; busyc = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      #3;
      if (o_vld) vldc++;
      if (o_busy) busyc++;
    end
    check("b2b_no_extra_vld", vldc, 0);
    check("b2b_no_extra_busy", busyc, 0);

    // Reset while word 7 of a UDP frame is on the bus
    tick();
    i_start = 1'b1; i_pkt_type = 4'd3; i_len_words = 9'd8;
    tick();
    i_start = 1'b0; i_rdy = 1'b1;
    n = 0; eop_seen = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #3;
      if (o_vld && i_rdy) begin
        n++;
        if (o_eop) eop_seen = 1;
      end
      tick();
    end
    rst = 1'b1;
    #3;
    check("midrst_vld_in_rst", 32'(o_vld), 32'd0);
    check("midrst_data_in_rst", o_data, 32'h0);
    tick();
    rst = 1'b0;
    #3;
    check("midrst_vld_after", 32'(o_vld), 32'd0);
    check("midrst_busy_after", 32'(o_busy), 32'd0);
    check("midrst_eop_seen", 32'(eop_seen), 32'd0);
    send_frame(4'd1, 0, 0, -1);
    check_common("arp_after_rst", frame_words(4'd1, 0), 0, 1'b0);
    check("arp_after_rst_w1", words[0], 32'h00001122);
`ifdef ETH_TX_PAD_EN
    for (int w = 11; w < 16; w++) check($sformatf("pad_w%0d", w + 1), words[w], 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
